// File: rtl/alu_slice_serial.sv
// alu_slice_serial: digit-serial ALU. WIDTH-bit operands are processed SLICE
// bits per clock, low slice first, through an AND/OR/ADD/LESS style cell with
// a registered carry between slices. Operands enter and results leave over
// valid/ready handshakes.
//
// Optional feature macro: ALU_SLICE_FLAGS_EN
//   defined   -> cout, overflow and zero are computed and registered
//   undefined -> cout, overflow and zero are tied to 0
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands/op valid
//   in_ready   out  block can accept (high only in IDLE)
//   a, b       in   WIDTH-bit operands
//   op         in   4-bit operation code
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts result
//   result     out  WIDTH-bit result
//   cout       out  carry out of MSB (ADD/SUB only)
//   overflow   out  signed overflow (ADD/SUB only)
//   zero       out  result == 0
module alu_slice_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand B is inverted for SUB/SLT (a + ~b + 1) and for NOR (~a & ~b).
  function automatic logic op_binv(input logic [3:0] f_op);
    logic v_inv;
    case (f_op)
      OP_SUB, OP_SLT, OP_NOR: v_inv = 1'b1;
      default:                v_inv = 1'b0;
    endcase
    return v_inv;
  endfunction

  function automatic logic op_legal(input logic [3:0] f_op);
    logic v_ok;
    case (f_op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: v_ok = 1'b1;
      default:                                               v_ok = 1'b0;
    endcase
    return v_ok;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_ainv;
  logic             w_binv;
  logic [SLICE-1:0] w_a_s;
  logic [SLICE-1:0] w_b_s;
  logic [SLICE-1:0] w_sum;
  logic [SLICE-1:0] w_slice_res;
  logic             w_slice_cout;
  logic             w_c_msb_in;
  logic             w_ovf_raw;
  logic [WIDTH-1:0] w_res_shift;
  logic [WIDTH-1:0] w_final;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_last    = (r_cnt == CW'(N - 1));
  assign w_ovf_raw = w_c_msb_in ^ w_slice_cout;

  // Slice datapath: ripple through SLICE cells starting from the carry register.
  always_comb begin
    logic v_c;
    w_ainv     = (r_op == OP_NOR);
    w_binv     = op_binv(r_op);
    w_a_s      = r_a[SLICE-1:0] ^ {SLICE{w_ainv}};
    w_b_s      = r_b[SLICE-1:0] ^ {SLICE{w_binv}};
    w_sum      = '0;
    v_c        = r_carry;
    w_c_msb_in = r_carry;
    for (int i = 0; i < SLICE; i++) begin
      w_c_msb_in = v_c;
      w_sum[i]   = w_a_s[i] ^ w_b_s[i] ^ v_c;
      v_c        = (w_a_s[i] & w_b_s[i]) | (w_a_s[i] & v_c) | (w_b_s[i] & v_c);
    end
    w_slice_cout = v_c;

    case (r_op)
      OP_AND:                 w_slice_res = w_a_s & w_b_s;
      OP_NOR:                 w_slice_res = w_a_s & w_b_s;  // both inputs inverted
      OP_OR:                  w_slice_res = w_a_s | w_b_s;
      OP_XOR:                 w_slice_res = w_a_s ^ w_b_s;
      OP_ADD, OP_SUB, OP_SLT: w_slice_res = w_sum;
      default:                w_slice_res = '0;
    endcase
  end

  // New slice enters the result register from the top; older slices move down.
  always_comb begin
    w_res_shift = r_res >> SLICE;
    w_res_shift[WIDTH-1 -: SLICE] = w_slice_res;
  end

  // Final-result fixups applied on the last slice (SLT compare, illegal op).
  always_comb begin
    w_final = '0;
    if (r_op == OP_SLT) begin
      // Sign of a-b corrected by overflow gives the signed less-than.
      w_final[0] = w_res_shift[WIDTH-1] ^ w_ovf_raw;
    end else if (op_legal(r_op)) begin
      w_final = w_res_shift;
    end else begin
      w_final = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_RUN;
        else          w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered handshake outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, slice stepping and result assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 4'b0000;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_carry <= op_binv(op) & (op != OP_NOR);
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> SLICE;
      r_b     <= r_b >> SLICE;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_res <= w_final;
      else        r_res <= w_res_shift;
    end else begin
      r_res <= r_res;
    end
  end

`ifdef ALU_SLICE_FLAGS_EN
  logic r_cout;
  logic r_ovf;
  logic r_zero;
  logic w_is_arith;

  assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  // Status flags captured together with the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_cout <= w_is_arith & w_slice_cout;
      r_ovf  <= w_is_arith & w_ovf_raw;
      r_zero <= (w_final == '0);
    end else begin
      r_cout <= r_cout;
      r_ovf  <= r_ovf;
      r_zero <= r_zero;
    end
  end

  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;
`else
  assign cout     = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_res;

endmodule

// File: tb/tb_alu_slice_serial.sv
// Scoreboard bench for alu_slice_serial (WIDTH=32, SLICE=8). Stimulus pushes
// hand-computed expected results; a negedge monitor pops and compares every
// result as it is handed over on out_valid&out_ready.
module tb_alu_slice_serial;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;
`ifdef ALU_SLICE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_slice_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare each delivered result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%08h, expected no output", result);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result",   result,          mon_e.res);
        chk("cout",     {31'd0, cout},     {31'd0, mon_e.c});
        chk("overflow", {31'd0, overflow}, {31'd0, mon_e.v});
        chk("zero",     {31'd0, zero},     {31'd0, mon_e.z});
      end
    end
  end

  // Issue one op (caller is at posedge+2), push its expectation, check latency.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] top,
                       input logic [31:0] e_res, input logic e_c, input logic e_v,
                       input logic e_z);
    exp_t e;
    int   t;
    int   lat;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb;
    op       = top;
    in_valid = 1'b1;
    e.res = e_res;
    e.c   = e_c & FLAGS;
    e.v   = e_v & FLAGS;
    e.z   = e_z & FLAGS;
    sb_q.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0;
    // Scramble the inputs: they must not be sampled after acceptance.
    a  = 32'hFFFF_FFFF;
    b  = 32'hFFFF_FFFF;
    op = OP_ADD;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("latency", lat, N);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'd0;
    b         = 32'd0;
    op        = 4'b0000;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {29'd0, cout, overflow, zero}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    issue(32'h00FF_00FF, 32'h0001_0001, OP_ADD, 32'h0100_0100, 1'b0, 1'b0, 1'b0);
    issue(32'hFFFF_FFFB, 32'h0000_0003, OP_SLT, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    issue(32'h7FFF_FFFF, 32'h8000_0000, OP_SLT, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_OR,  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_XOR, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0);
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_NOR, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0101, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // Back-pressure: hold out_ready low for 5 cycles in DONE.
    @(posedge clk); #2;
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h1111_1111, OP_ADD, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result",    result,             32'h2345_6789);
      chk("hold_flags",     {29'd0, cout, overflow, zero}, 32'd0);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // Abort an op with reset during its second RUN cycle; it must never appear.
    @(posedge clk); #2;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    a        = 32'h0000_0001;
    b        = 32'h0000_0002;
    op       = OP_ADD;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result",    result,             32'd0);
    chk("abort_flags",     {29'd0, cout, overflow, zero}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    issue(32'h0000_0005, 32'h0000_0007, OP_ADD, 32'h0000_000C, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck handshake.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
